hhk_loop_adder: RTL
===================

HHK_LOOP_ADDER -- requirements
Module: hhk_loop_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11: datapath width of a, b, cnt and res.
REQ-002 The block SHALL have parameter MODE_EN, default 1: when 1, the mode input selects add/subtract; when 0, the block always adds and ignores mode.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-006 Port mode, input, 1 bit: 0 = increment res per step, 1 = decrement res per step; latched with start.
REQ-007 Port abort, input, 1 bit: cancels a running operation.
REQ-008 Port a_in, input, WIDTH: initial value for res.
REQ-009 Port b_in, input, WIDTH: iteration count.
REQ-010 Port a, output, WIDTH: latched a_in of the current or last operation.
REQ-011 Port b, output, WIDTH: latched b_in of the current or last operation.
REQ-012 Port cnt, output, WIDTH: remaining iterations.
REQ-013 Port res, output, WIDTH: running result.
REQ-014 Port busy, output, 1 bit: high in RUN and DONE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port ovf, output, 1 bit: sticky wrap flag for the current or last operation.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, RUN, DONE. All outputs SHALL be registered or decoded from state only.
REQ-018 IDLE, start=1 at an edge: the block SHALL latch a=a_in, b=b_in, res=a_in, cnt=b_in, mode, clear ovf, and go to RUN.
REQ-019 IDLE, start=0: all registers SHALL hold.
REQ-020 RUN, cnt!=0, abort=0: per edge, cnt SHALL become cnt-1 and res SHALL become res+1 (mode 0) or res-1 (mode 1), modulo 2^WIDTH.
REQ-021 RUN, cnt==0, abort=0: the block SHALL go to DONE with res and cnt unchanged.
REQ-022 ovf SHALL be set on any step where res wraps (add from 2^WIDTH-1 to 0; subtract from 0 to 2^WIDTH-1). It SHALL stay set until the next accepted start or reset.
REQ-023 DONE: done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-024 Latency: done SHALL be high in the cycle following the (b_in+1)th edge after the accepting edge.
REQ-025 start asserted in RUN or DONE SHALL be ignored and SHALL not be queued.
REQ-026 abort=1 in RUN SHALL take priority over stepping: the block goes to IDLE, done is not asserted, and a, b, cnt, res, ovf hold their values.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 Invariant in RUN/DONE: res == a + (b - cnt) in mode 0, and res == a - (b - cnt) in mode 1, modulo 2^WIDTH.
REQ-029 After DONE, a, b, cnt(=0), res and ovf SHALL hold until the next accepted start.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, and a, b, cnt, res = 0, busy = done = ovf = 0, latched mode = 0, regardless of clock.
REQ-031 Reset asserted mid-RUN SHALL discard the operation with no done pulse.
REQ-032 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-033 Add: a_in=5, b_in=3, mode=0 -> res=8, cnt=0, ovf=0; done high after the 4th edge from accept.
REQ-034 Zero count: a_in=9, b_in=0 -> res=9; done high after the 1st edge from accept; busy for 2 cycles.
REQ-035 Wrap: WIDTH=11, a_in=2047, b_in=1, mode=0 -> res=0, ovf=1. Subtract: a_in=2, b_in=5, mode=1 -> res=2045, ovf=1.
REQ-036 Abort: a_in=0, b_in=10, abort at 3rd RUN edge -> IDLE, cnt=8, res=2, no done pulse; start re-accepted next cycle.
REQ-037 Reset mid-RUN (b_in=100) -> all outputs 0 asynchronously; start ignored during busy; 1000-cycle random start/mode/b_in run checks REQ-028 every cycle.

Source files
------------

// File: rtl/hhk_loop_adder_if.sv
// Handshake/data bundle for hhk_loop_adder: operation request in, running state out.
interface hhk_loop_adder_if #(
    parameter int WIDTH = 11
);
    logic             start;
    logic             mode;
    logic             abort;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, mode, abort, a_in, b_in,
        input  a, b, cnt, res, busy, done, ovf
    );

    modport slave (
        input  start, mode, abort, a_in, b_in,
        output a, b, cnt, res, busy, done, ovf
    );
endinterface

// File: rtl/hhk_loop_adder.sv
// Iterative adder: steps res by +/-1 once per clock for b_in cycles, with abort,
// sticky wrap detection and a one-cycle done pulse.
module hhk_loop_adder #(
    parameter int WIDTH   = 11,
    parameter bit MODE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    hhk_loop_adder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL1 = '1;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, cnt_q, res_q;
    logic             mode_q, ovf_q;
    logic [WIDTH-1:0] res_d;
    logic             wrap_d;

    // Next step value and whether this step crosses the modulo boundary.
    always_comb begin
        res_d  = mode_q ? (res_q - ONE) : (res_q + ONE);
        wrap_d = mode_q ? (res_q == '0) : (res_q == ALL1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        res_q   <= bus.a_in;
                        cnt_q   <= bus.b_in;
                        mode_q  <= MODE_EN ? bus.mode : 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over stepping and leaves the datapath frozen.
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - ONE;
                        res_q <= res_d;
                        if (wrap_d) ovf_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.cnt  = cnt_q;
    assign bus.res  = res_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
endmodule
